// File: rtl/fp32_vec_accum.sv
// Streaming fp32 packet accumulator wrapped around an external combinational fp32 adder.
// Holds the running sum, counts elements, and presents the packet sum on a valid/ready port.
module fp32_vec_accum #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    input  logic             in_last_i,
    output logic [31:0]      add_a_o,
    output logic [31:0]      add_b_o,
    input  logic [31:0]      add_result_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_sum_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_nan_o,
    output logic             out_inf_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             accept_s;

    assign accept_s = in_valid_i && (state_q != HOLD);

    // Next-state and datapath selection.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    // First element bypasses the adder so -0.0 and NaN payloads survive.
                    if (in_last_i) begin
                        out_sum_d   = in_data_i;
                        out_count_d = CNT_ONE;
                        state_d     = HOLD;
                    end else begin
                        acc_d   = in_data_i;
                        cnt_d   = CNT_ONE;
                        state_d = ACC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (accept_s) begin
                    if (in_last_i) begin
                        out_sum_d   = add_result_i;
                        out_count_d = sat_inc(cnt_q);
                        state_d     = HOLD;
                    end else begin
                        acc_d   = add_result_i;
                        cnt_d   = sat_inc(cnt_q);
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    acc_d   = 32'h0000_0000;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= 32'h0000_0000;
            cnt_q       <= '0;
            out_sum_q   <= 32'h0000_0000;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready_o  = (state_q != HOLD);
    assign out_valid_o = (state_q == HOLD);
    assign add_a_o     = acc_q;
    assign add_b_o     = in_data_i;
    assign out_sum_o   = out_sum_q;
    assign out_count_o = out_count_q;
    assign out_nan_o   = out_valid_o && (out_sum_q[30:23] == 8'hFF) && (out_sum_q[22:0] != 23'h0);
    assign out_inf_o   = out_valid_o && (out_sum_q[30:23] == 8'hFF) && (out_sum_q[22:0] == 23'h0);

endmodule

// File: tb/tb_fp32_vec_accum.sv
// Directed bench for fp32_vec_accum with a behavioural fp32 adder and an expected-result queue.
module tb_fp32_vec_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data, add_a, add_b, add_result;
    logic        out_valid, out_ready, out_nan, out_inf;
    logic [31:0] out_sum;
    logic [15:0] out_count;

    logic        s4_in_valid, s4_in_ready, s4_in_last;
    logic [31:0] s4_in_data, s4_add_a, s4_add_b, s4_add_result;
    logic        s4_out_valid, s4_out_ready, s4_out_nan, s4_out_inf;
    logic [31:0] s4_out_sum;
    logic [3:0]  s4_out_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] sum;
        logic [15:0] cnt;
        logic        nan;
        logic        inf;
        logic        chk_sum;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    // fp32 -> fp64 (normals, zeros, inf/NaN; denormals flushed).
    function automatic real f32_to_real(input logic [31:0] f);
        logic [63:0] b;
        if (f[30:23] == 8'hFF)
            b = {f[31], 11'h7FF, f[22:0], 29'h0};
        else if (f[30:23] == 8'h00)
            b = {f[31], 63'h0};
        else
            b = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
        return $bitstoreal(b);
    endfunction

    // fp64 -> fp32 for the exactly representable sums used here, overflow to inf.
    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        int          ue;
        b  = $realtobits(r);
        ue = int'(b[62:52]) - 1023 + 127;
        if (b[62:52] == 11'h7FF)
            return {b[63], 8'hFF, (b[51:0] != 52'h0) ? 23'h40_0000 : 23'h0};
        else if (b[62:52] == 11'h000 || ue <= 0)
            return {b[63], 31'h0};
        else if (ue >= 255)
            return {b[63], 8'hFF, 23'h0};
        else
            return {b[63], 8'(ue), b[51:29]};
    endfunction

    assign add_result    = real_to_f32(f32_to_real(add_a) + f32_to_real(add_b));
    assign s4_add_result = real_to_f32(f32_to_real(s4_add_a) + f32_to_real(s4_add_b));

    fp32_vec_accum #(.CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .add_a_o(add_a), .add_b_o(add_b), .add_result_i(add_result),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sum_o(out_sum),
        .out_count_o(out_count), .out_nan_o(out_nan), .out_inf_o(out_inf)
    );

    fp32_vec_accum #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(s4_in_valid), .in_ready_o(s4_in_ready), .in_data_i(s4_in_data), .in_last_i(s4_in_last),
        .add_a_o(s4_add_a), .add_b_o(s4_add_b), .add_result_i(s4_add_result),
        .out_valid_o(s4_out_valid), .out_ready_i(s4_out_ready), .out_sum_o(s4_out_sum),
        .out_count_o(s4_out_count), .out_nan_o(s4_out_nan), .out_inf_o(s4_out_inf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] s, input logic [15:0] c, input logic n, input logic i,
                            input logic cs);
        exp_t e;
        e.sum = s; e.cnt = c; e.nan = n; e.inf = i; e.chk_sum = cs;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            if (e.chk_sum) chk({tag, "_sum"}, out_sum, e.sum);
            chk({tag, "_count"}, {16'h0, out_count}, {16'h0, e.cnt});
            chk({tag, "_nan"}, {31'h0, out_nan}, {31'h0, e.nan});
            chk({tag, "_inf"}, {31'h0, out_inf}, {31'h0, e.inf});
        end
    endtask

    task automatic wait_output(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        check_head(tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_drain_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0; out_ready = 1'b0;
        s4_in_valid = 1'b0; s4_in_data = 32'h0; s4_in_last = 1'b0; s4_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_count", {16'h0, out_count}, 32'h0);
        chk("rst_acc", add_a, 32'h0);
        chk("rst_flags", {30'h0, out_nan, out_inf}, 32'h0);
        rst = 1'b0;

        // Reset mid-packet discards the partial sum.
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        in_valid = 1'b0;
        chk("mid_acc", add_a, 32'h4040_0000);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_acc", add_a, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_exp(32'h3F80_0000, 16'd1, 1'b0, 1'b0, 1'b1);
        send(32'h3F80_0000, 1'b1);
        in_valid = 1'b0;
        wait_output("after_rst");

        // Reset while holding a result.
        send(32'h4000_0000, 1'b1);
        in_valid = 1'b0;
        chk("hold_valid", {31'h0, out_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("hold_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("hold_rst_ready", {31'h0, in_ready}, 32'h1);
        chk("hold_rst_count", {16'h0, out_count}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic three-element sum with single-cycle latency.
        push_exp(32'h40C0_0000, 16'd3, 1'b0, 1'b0, 1'b1);
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b1);
        in_valid = 1'b0;
        chk("basic_latency", {31'h0, out_valid}, 32'h1);
        wait_output("basic");

        // Negative zero passes through untouched.
        push_exp(32'h8000_0000, 16'd1, 1'b0, 1'b0, 1'b1);
        send(32'h8000_0000, 1'b1);
        in_valid = 1'b0;
        wait_output("negzero");

        // Backpressure: result held while next packet waits.
        push_exp(32'h3F80_0000, 16'd1, 1'b0, 1'b0, 1'b1);
        send(32'h3F80_0000, 1'b1);
        in_valid = 1'b1; in_data = 32'h4000_0000; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_sum_stable", out_sum, 32'h3F80_0000);
        end
        chk("bp_valid", {31'h0, out_valid}, 32'h1);
        check_head("bp_first");
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_hs_ready", {31'h0, in_ready}, 32'h1);
        chk("bp_hs_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_exp(32'h4000_0000, 16'd1, 1'b0, 1'b0, 1'b1);
        chk("bp_next_accept", {31'h0, out_valid}, 32'h1);
        wait_output("bp_second");

        // inf + -inf gives NaN; max + max overflows to inf.
        push_exp(32'h0, 16'd2, 1'b1, 1'b0, 1'b0);
        send(32'h7F80_0000, 1'b0);
        send(32'hFF80_0000, 1'b1);
        in_valid = 1'b0;
        wait_output("nan");
        push_exp(32'h7F80_0000, 16'd2, 1'b0, 1'b1, 1'b1);
        send(32'h7F7F_FFFF, 1'b0);
        send(32'h7F7F_FFFF, 1'b1);
        in_valid = 1'b0;
        wait_output("inf");

        // Random gaps: 1.5 + 2.25 - 0.5 + 10.0 = 13.25.
        push_exp(32'h4154_0000, 16'd4, 1'b0, 1'b0, 1'b1);
        begin
            logic [31:0] elems [4];
            elems[0] = 32'h3FC0_0000; elems[1] = 32'h4010_0000;
            elems[2] = 32'hBF00_0000; elems[3] = 32'h4120_0000;
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                send(elems[i], (i == 3) ? 1'b1 : 1'b0);
            end
            in_valid = 1'b0;
        end
        wait_output("gaps");

        // Saturating count on the 4-bit instance: 20 x 1.0.
        for (int i = 0; i < 20; i++) begin
            s4_in_valid = 1'b1;
            s4_in_data  = 32'h3F80_0000;
            s4_in_last  = (i == 19) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        s4_in_valid = 1'b0;
        chk("sat_valid", {31'h0, s4_out_valid}, 32'h1);
        chk("sat_count", {28'h0, s4_out_count}, 32'h0000_000F);
        chk("sat_sum", s4_out_sum, 32'h41A0_0000);
        chk("sat_flags", {30'h0, s4_out_nan, s4_out_inf}, 32'h0);
        s4_out_ready = 1'b1;
        @(posedge clk); #1;
        s4_out_ready = 1'b0;
        chk("sat_drain", {31'h0, s4_out_valid}, 32'h0);

        chk("sb_empty_end", sb_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp32_vec_accum.md
# fp32_vec_accum

Streaming single-precision accumulator that sits directly around the combinational `fp32_adder`. It accepts a packet of IEEE-754 fp32 values over a valid/ready stream and drives the adder's `a`/`b` operands from its running-sum register and the incoming element. It consumes the adder's `result` once per accepted element and presents the packet sum, with element count and special-value flags, on a valid/ready output port.

## Interface
- `CNT_W`, default 16: width of the element counter and `out_count`.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset: asynchronous, active-high; clears all state
- `in_valid`  in  1  element valid
- `in_ready`  out  1  element accepted when `in_valid && in_ready`
- `in_data`  in  32  fp32 element
- `in_last`  in  1  marks final element of packet
- `add_a`  out  32  to `fp32_adder.a`: running-sum register `acc`
- `add_b`  out  32  to `fp32_adder.b`: `in_data`, combinational passthrough
- `add_result`  in  32  from `fp32_adder.result`
- `out_valid`  out  1  packet sum valid
- `out_ready`  in  1  downstream accepts
- `out_sum`  out  32  packet sum
- `out_count`  out  CNT_W  elements in packet, saturating
- `out_nan`  out  1  `out_sum` exponent == 8'hFF and mantissa != 0
- `out_inf`  out  1  `out_sum` exponent == 8'hFF and mantissa == 0

## Operation
- FSM states: IDLE (no element of the current packet accepted yet), ACC (mid-packet), HOLD (result presented).
- `in_ready` = (state != HOLD). It depends on state only and never on `in_valid`.
- "Accept" means `in_valid && in_ready`.
- IDLE, accept, `in_last`=0:
  - `acc <= in_data`. The value is loaded verbatim and bypasses the adder, so -0.0 and NaN payloads are preserved.
  - `cnt <= 1`; go to ACC.
- IDLE, accept, `in_last`=1:
  - `out_sum <= in_data`, `out_count <= 1`; go to HOLD.
- ACC, accept, `in_last`=0:
  - `acc <= add_result`, `cnt <= sat(cnt+1)`; stay in ACC.
- ACC, accept, `in_last`=1:
  - `out_sum <= add_result`, `out_count <= sat(cnt+1)`; go to HOLD.
- IDLE or ACC with no accept: hold all state.
- HOLD:
  - `out_valid`=1.
  - `out_sum` and `out_count` stay stable until `out_valid && out_ready`.
  - On that handshake: `acc <= 32'h0`, `cnt <= 0`, go to IDLE.
- `sat(x)`: clamps at all-ones. A count of 2^CNT_W or more reports all-ones.
- `out_nan` and `out_inf` decode combinationally from registered `out_sum`. They are qualified by `out_valid` and are 0 whenever `out_valid`=0.
- Arithmetic (rounding, NaN generation, overflow to inf) is owned entirely by `fp32_adder`. This block does no fp arithmetic itself.

## Timing
- Reset values: state=IDLE, `acc`=0, `cnt`=0, `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_nan`=0, `out_inf`=0.
- Throughput: one element per cycle while in IDLE or ACC.
- Critical path: `acc` → adder → `acc` completes in a single cycle.
- Latency: last element accepted at edge k → `out_valid`=1 after edge k.
- Output handshake at edge m → `in_ready`=1 after edge m. The first element of the next packet is therefore accepted at edge m+1 at the earliest.
- `in_ready` is 0 throughout HOLD, including the handshake cycle. Packets never overlap.
- `out_valid` must not drop without `out_ready`. `in_data`/`in_last` are sampled only on accept.
- Reset asserted mid-packet or in HOLD: all state clears immediately (asynchronous), and the partial sum is discarded. Release is synchronised by the system.

## Test plan
- Reset values: assert `rst` mid-packet → `out_valid`=0 and `in_ready`=1 immediately. After release, a 1-element packet 3F800000 → `out_sum`=3F800000, `out_count`=1.
- Basic sum: stream 3F800000, 40000000, 40400000 (last) on consecutive cycles → `out_sum`=40C00000 (6.0), `out_count`=3, `out_valid` one cycle after the last accept, flags 0.
- Single element -0.0 (80000000, last) → `out_sum`=80000000 exactly (bypass path), `out_count`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0 and `out_sum` stable throughout. Raise `out_ready` → next packet accepted exactly one cycle after the handshake.
- Specials: 7F800000 + FF800000 (last) → `out_nan`=1. 7F7FFFFF + 7F7FFFFF → `out_sum`=7F800000, `out_inf`=1.
- Gaps and saturation: `in_valid` toggling randomly in a 4-element packet → sum matches the reference model. With CNT_W=4, a 20-element packet → `out_count`=4'hF.
